// File: rtl/axis_gauss3x3_pkg.sv
// Shared types and constants for the 3x3 Gaussian stream filter.
package gauss_pkg;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam int K_CORNER = 1;
  localparam int K_EDGE   = 2;
  localparam int K_CENTER = 4;
  localparam int RND      = 8;
  localparam int SHIFT    = 4;

  // Width that can hold a full frame's component count, including the value N itself.
  function automatic int cnt_w(input int width, input int height, input int channels);
    return $clog2(width * height * channels + 1);
  endfunction

endpackage

// File: rtl/axis_gauss3x3_if.sv
// AXI-Stream beat bundle; the filter generates tlast itself, so the slave side ignores it.
interface axis_gauss3x3_if #(
  parameter int DATA_W = 8
);
  logic              tvalid;
  logic              tready;
  logic [DATA_W-1:0] tdata;
  logic              tlast;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/axis_gauss3x3_line_fifo.sv
// One-line delay memory: a circular buffer whose single pointer both reads and writes.
module line_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     ptr;

  // Slot under the pointer holds the value written DEPTH enables ago.
  assign dout = mem[ptr];

  always_ff @(posedge clk) begin
    if (en) mem[ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (en) begin
      ptr <= (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    end
  end

endmodule

// File: rtl/axis_gauss3x3.sv
// 3x3 Gaussian smoothing over an interleaved raster stream, with per-frame bypass and frame-end flush.
//  state | meaning
//  FILL  | accept the first D components of a frame, no output yet
//  RUN   | each accepted input releases the output D components behind it
//  FLUSH | input blocked, window advanced internally until the last output is taken
module axis_gauss3x3
  import gauss_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int IMG_WIDTH  = 945,
  parameter int IMG_HEIGHT = 630,
  parameter int CHANNELS   = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   filter_en,
  axis_gauss3x3_if.slave         s_axis,
  axis_gauss3x3_if.master        m_axis
);

  localparam int L    = IMG_WIDTH * CHANNELS;
  localparam int N    = L * IMG_HEIGHT;
  localparam int D    = L + CHANNELS;
  localparam int CW   = cnt_w(IMG_WIDTH, IMG_HEIGHT, CHANNELS);
  localparam int COLW = (L > 1) ? $clog2(L) : 1;
  localparam int ROWW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int WW   = 2 * CHANNELS + 1;
  localparam int SW   = DATA_W + 4;
  localparam int TC   = CHANNELS;
  localparam int TM   = 2 * CHANNELS;

  state_t            state;
  logic [CW-1:0]     in_cnt;
  logic [COLW-1:0]   col;
  logic [ROWW-1:0]   row;
  logic              fen_q;
  logic              m_valid;
  logic              m_last;
  logic [DATA_W-1:0] m_data;

  logic              adv;
  logic              s_ready;
  logic              push_in;
  logic              flush_push;
  logic              push;
  logic              emit;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] f1_out;
  logic [DATA_W-1:0] f2_out;
  logic [DATA_W-1:0] newc [3];
  logic [DATA_W-1:0] win  [3][WW];
  logic [DATA_W-1:0] nxt  [3][WW];
  logic [SW-1:0]     corners;
  logic [SW-1:0]     edges;
  logic [SW-1:0]     centre;
  logic [SW-1:0]     sum;
  logic [DATA_W-1:0] filt;
  logic              border;
  logic              last_pos;
  logic [DATA_W-1:0] out_val;

  assign adv        = !m_valid || m_axis.tready;
  assign s_ready    = rst_n && adv && (state != FLUSH);
  assign push_in    = s_axis.tvalid && s_ready;
  // Stop stepping once the final output is loaded; it leaves on its own handshake.
  assign flush_push = (state == FLUSH) && adv && !m_last;
  assign push       = push_in || flush_push;
  assign emit       = push && (state != FILL);
  assign data_in    = push_in ? s_axis.tdata : '0;

  assign s_axis.tready = s_ready;
  assign m_axis.tvalid = m_valid;
  assign m_axis.tdata  = m_data;
  assign m_axis.tlast  = m_last;

  line_fifo #(.DATA_W(DATA_W), .DEPTH(L)) u_line1 (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (push),
    .din  (data_in),
    .dout (f1_out)
  );

  line_fifo #(.DATA_W(DATA_W), .DEPTH(L)) u_line2 (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (push),
    .din  (f1_out),
    .dout (f2_out)
  );

  // Row 2 is the line below the centre, row 0 the line above; column 0 is the +CHANNELS neighbour.
  assign newc[0] = f2_out;
  assign newc[1] = f1_out;
  assign newc[2] = data_in;

  always_comb begin
    for (int r = 0; r < 3; r++) begin
      nxt[r][0] = newc[r];
      for (int j = 1; j < WW; j++) begin
        nxt[r][j] = win[r][j-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) win <= nxt;
  end

  always_comb begin
    corners = SW'(nxt[0][0]) + SW'(nxt[0][TM]) + SW'(nxt[2][0]) + SW'(nxt[2][TM]);
    edges   = SW'(nxt[0][TC]) + SW'(nxt[1][0]) + SW'(nxt[1][TM]) + SW'(nxt[2][TC]);
    centre  = SW'(nxt[1][TC]);
    sum     = SW'(K_CORNER) * corners + SW'(K_EDGE) * edges + SW'(K_CENTER) * centre;
    filt    = DATA_W'((sum + SW'(RND)) >> SHIFT);
  end

  // col/row track the component about to be emitted, not the one being accepted.
  assign border   = (row == '0) || (row == ROWW'(IMG_HEIGHT - 1)) ||
                    (col < COLW'(CHANNELS)) || (col >= COLW'(L - CHANNELS));
  assign last_pos = (row == ROWW'(IMG_HEIGHT - 1)) && (col == COLW'(L - 1));
  assign out_val  = (fen_q && !border) ? filt : nxt[1][TC];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= FILL;
      in_cnt  <= '0;
      col     <= '0;
      row     <= '0;
      fen_q   <= 1'b0;
      m_valid <= 1'b0;
      m_data  <= '0;
      m_last  <= 1'b0;
    end else begin
      if (push_in) in_cnt <= in_cnt + 1'b1;
      if (push_in && (in_cnt == '0)) fen_q <= filter_en;

      if (emit) begin
        m_valid <= 1'b1;
        m_data  <= out_val;
        m_last  <= last_pos;
        if (col == COLW'(L - 1)) begin
          col <= '0;
          row <= (row == ROWW'(IMG_HEIGHT - 1)) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end else if (m_axis.tready) begin
        m_valid <= 1'b0;
      end

      case (state)
        FILL:    if (push_in && (in_cnt == CW'(D - 1))) state <= RUN;
        RUN:     if (push_in && (in_cnt == CW'(N - 1))) state <= FLUSH;
        FLUSH: begin
          if (m_valid && m_axis.tready && m_last) begin
            state  <= FILL;
            in_cnt <= '0;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: doc/axis_gauss3x3.md
# axis_gauss3x3

Parametrised AXI-Stream 3x3 Gaussian smoothing filter for raster images streamed one component per beat, such as BMP BGR byte order, bottom-up, with the header stripped. It is the next-generation drop-in for the image DUT slot between the file-reader stimulus and the output file writer. It generalises to any data width, image size and interleaved channel count. It adds per-frame bypass, a frame-end flush that keeps output count equal to input count, full backpressure, and an `m_axis_tlast` output.

## Interface
- `DATA_W`, 8: bits per colour component.
- `IMG_WIDTH`, 945: pixels per line.
- `IMG_HEIGHT`, 630: lines per frame.
- `CHANNELS`, 3: interleaved components per pixel.
- `clk` in 1: single clock; all logic on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset; one clock; reset is asynchronous and active-low.
- `filter_en` in 1: 1 = filter, 0 = bypass; sampled on the first input beat of each frame.
- `s_axis_tvalid` in 1: input component valid.
- `s_axis_tready` out 1: block can accept an input component.
- `s_axis_tdata` in `DATA_W`: input component.
- `m_axis_tvalid` out 1: output component valid.
- `m_axis_tready` in 1: downstream accepts the output component.
- `m_axis_tdata` out `DATA_W`: filtered component.
- `m_axis_tlast` out 1: high on the last component of the frame.

## Operation
- Derived sizes:
  - L = `IMG_WIDTH*CHANNELS` components per line.
  - N = L*`IMG_HEIGHT` components per frame.
  - D = L+`CHANNELS`, the window lookahead.
- Neighbours of a component are same-channel components:
  - ±`CHANNELS` along the line.
  - ±L across lines.
- Interior components, with pixel column in 1..W-2 and row in 1..H-2, use kernel [1 2 1; 2 4 2; 1 2 1].
  - sum is `DATA_W+4` bits.
  - out = (sum+8)>>4.
  - The result never exceeds 2^`DATA_W`-1, so no saturation is needed.
- Border components are passed through unchanged. When bypass is selected, every component is passed through.
- Output order equals input order, with exactly N outputs per frame.
- State machine:
  - FILL: accept inputs and produce no output until D components have been accepted, then go to RUN.
  - RUN: each accepted input k+D releases output k. After input N-1 is accepted, go to FLUSH.
  - FLUSH: `s_axis_tready`=0. Internally advance the window and emit the remaining D outputs. After output N-1 completes its handshake, go to FILL for the next frame.
- Bypass uses the same pipeline and latency, so frame timing is identical in both modes.
- Storage: two line buffers of L components each, plus a 3-row by (2*`CHANNELS`+1) window register.

## Timing
- Reset values:
  - `s_axis_tready`=0 during reset, and 1 from the first cycle after `rst_n` deasserts.
  - `m_axis_tvalid`=0, `m_axis_tdata`=0, `m_axis_tlast`=0.
  - State = FILL; all counters = 0.
- Line buffer contents are not reset.
- Pipeline advance: adv = !`m_axis_tvalid` || `m_axis_tready`.
  - In FILL and RUN, `s_axis_tready` = adv.
  - In FLUSH, the window advances on adv with no input.
- The output is a single register. `m_axis_tvalid` for component k rises the cycle after the handshake of input k+D, or after the matching flush step.
- While `m_axis_tvalid`=1 and `m_axis_tready`=0:
  - `m_axis_tdata` and `m_axis_tlast` hold stable.
  - No input is accepted.
- Throughput is one component per cycle when both sides are always ready.
- `s_axis_tvalid` low in FILL or RUN stalls the pipeline with no bubble artefacts.
- Simultaneous output handshake and input handshake in the same cycle is allowed; this is the normal streaming case.
- Counters:
  - The column counter wraps at L-1.
  - The row counter wraps at `IMG_HEIGHT`-1.
  - The frame counter clears at the FLUSH→FILL transition.
- `rst_n` low mid-frame aborts the frame immediately:
  - Outputs take their reset values.
  - The next frame starts from component 0.
- `filter_en` changes mid-frame are ignored until the next frame.

## Structure
- Package `gauss_pkg`:
  - State enum {FILL, RUN, FLUSH}.
  - Kernel weight constants.
  - Rounding constant 8 and shift 4.
  - Function computing counter width from `IMG_WIDTH`/`IMG_HEIGHT`/`CHANNELS`.
- One sub-module, `line_fifo`: a parametrised depth-L, `DATA_W`-wide circular shift memory with a single read/write pointer that advances on enable. It is instantiated twice and maps to block RAM.
- The top level holds the FSM, counters, window registers, border detection, adder tree and output register.

## Test plan
All cases use `DATA_W`=8, `IMG_WIDTH`=4, `IMG_HEIGHT`=3, `CHANNELS`=1 unless stated; N=12, D=5.
- Constant image, all 100, `filter_en`=1, both ready always → 12 outputs, all 100. First output valid the cycle after input 5. `m_axis_tlast` high only on output 12.
- Impulse at pixel (row 1, col 1) = 160, all else 0, `filter_en`=1:
  - Output (1,1) = 40.
  - Output (1,2) = 20.
  - All other outputs are 0, border included.
- Same impulse frame with `filter_en`=0 → output equals input exactly, with the same latency.
- Random `m_axis_tready` (50%) and random `s_axis_tvalid` gaps on a ramp image 0..11:
  - Output sequence matches the golden model.
  - No data changes while stalled.
  - Exactly 12 outputs.
- Mid-frame reset after 7 inputs, then one full constant-50 frame:
  - Outputs read 0 during reset.
  - Then exactly 12 outputs of 50.
  - No stale data from the aborted frame.
- `CHANNELS`=3, `IMG_WIDTH`=4, `IMG_HEIGHT`=3 with B=10, G=20, R=30 constant:
  - 36 outputs repeating 10,20,30.
  - Channels never mixed.
  - `m_axis_tlast` on output 36.
